calc_chain_sequencer: RTL and testbench

- Controller that sequences a chained-operation calculation through a shared, multicycle sign-magnitude arithmetic unit (ALU).
- Accepts operand/operator pairs over a valid/ready input, keeps a running 9-bit sign-magnitude accumulator, and issues one ALU operation per accepted input.
- Sets zero, sign and error status flags, and halts after MAX_OPS operands, on a divide error, or on an ALU timeout.
- Sits between the switch/key input front end and the ALU; the display logic consumes its accumulator and flags.

---
 rtl/calc_chain_sequencer.sv | 131 +++++++++++++
 tb/tb_calc_chain_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_chain_sequencer.sv
// Chained-operation sequencer: accepts operand/operator pairs, drives a shared
// multicycle sign-magnitude ALU and keeps a running 9-bit accumulator with status.
module calc_chain_sequencer #(
  parameter int unsigned MAX_OPS     = 5,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_operand,
  input  logic [1:0] in_op,
  output logic       alu_start,
  output logic [8:0] alu_a,
  output logic [8:0] alu_b,
  output logic [1:0] alu_op,
  input  logic       alu_done,
  input  logic [8:0] alu_result,
  input  logic       alu_error,
  output logic [8:0] acc,
  output logic [3:0] step_count,
  output logic       flag_zero,
  output logic       flag_sign,
  output logic       flag_error,
  output logic       err_timeout,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    WAIT_IN,
    ISSUE,
    WAIT_ALU,
    COMMIT,
    HALT
  } state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  tcnt;
  logic [8:0]     result_q;
  logic [8:0]     b_norm;
  logic [3:0]     step_inc;
  logic           timeout_hit;

  // Negative zero operands are folded to +0 before they reach acc or the ALU.
  assign b_norm      = {in_operand[2] & (in_operand[1:0] != 2'b00), 6'b0, in_operand[1:0]};
  assign timeout_hit = (tcnt == TW'(ALU_TIMEOUT - 1));
  assign step_inc    = step_count + 4'd1;

  assign flag_zero = (acc[7:0] == 8'd0);
  assign flag_sign = acc[8];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    alu_start = 1'b0;
    busy      = 1'b0;
    case (state)
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid && step_count != 4'd0) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_start = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT_ALU;
      end
      WAIT_ALU: begin
        busy = 1'b1;
        // A result arriving on the timeout cycle takes precedence over the timeout.
        if (alu_done)         state_nxt = alu_error ? HALT : COMMIT;
        else if (timeout_hit) state_nxt = HALT;
      end
      COMMIT:  state_nxt = (step_inc == 4'(MAX_OPS)) ? HALT : WAIT_IN;
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= WAIT_IN;
      acc         <= '0;
      step_count  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      tcnt        <= '0;
      result_q    <= '0;
      flag_error  <= 1'b0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        WAIT_IN: begin
          if (in_valid) begin
            if (step_count == 4'd0) begin
              acc        <= b_norm;
              step_count <= 4'd1;
            end else begin
              alu_a  <= {acc[8], 1'b0, acc[6:0]};
              alu_b  <= b_norm;
              alu_op <= in_op;
            end
          end
        end
        ISSUE: tcnt <= '0;
        WAIT_ALU: begin
          tcnt <= tcnt + 1'b1;
          if (alu_done) begin
            if (alu_error) flag_error <= 1'b1;
            else           result_q   <= alu_result;
          end else if (timeout_hit) begin
            flag_error  <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        COMMIT: begin
          acc        <= {result_q[8] & (result_q[7:0] != 8'd0), result_q[7:0]};
          step_count <= step_inc;
          if (step_inc == 4'(MAX_OPS)) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_chain_sequencer.sv
// Self-checking bench for calc_chain_sequencer: directed vector table, hand-written
// corner sequences and randomized chains against an integer-arithmetic reference model.
module tb_calc_chain_sequencer;

  localparam int MAX_OPS     = 5;
  localparam int ALU_TIMEOUT = 15;

  logic       Clk = 1'b0;
  logic       Reset, in_valid, alu_done, alu_error;
  logic [2:0] in_operand;
  logic [1:0] in_op;
  logic [8:0] alu_result;
  logic       in_ready, alu_start, flag_zero, flag_sign, flag_error, err_timeout, busy, done;
  logic [8:0] alu_a, alu_b, acc;
  logic [1:0] alu_op;
  logic [3:0] step_count;

  calc_chain_sequencer #(.MAX_OPS(MAX_OPS), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_operand(in_operand), .in_op(in_op), .alu_start(alu_start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_done(alu_done),
    .alu_result(alu_result), .alu_error(alu_error), .acc(acc),
    .step_count(step_count), .flag_zero(flag_zero), .flag_sign(flag_sign),
    .flag_error(flag_error), .err_timeout(err_timeout), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accumulator as a plain signed integer plus status bits.
  int m_acc, m_steps;
  bit m_halt, m_err, m_to, m_done;
  logic [8:0] last_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [8:0] enc(input int v);
    return {v < 0, 8'(iabs(v))};
  endfunction

  function automatic int sm_val(input logic [2:0] o);
    return o[2] ? -int'(o[1:0]) : int'(o[1:0]);
  endfunction

  // Behavioural ALU driven from what the DUT actually presents on its ALU bus.
  function automatic void alu_fn(input logic [8:0] a, input logic [8:0] b, input logic [1:0] op,
                                 output logic [8:0] r, output logic err);
    int va, vb, v;
    logic [15:0] m;
    va  = a[8] ? -int'(a[7:0]) : int'(a[7:0]);
    vb  = b[8] ? -int'(b[7:0]) : int'(b[7:0]);
    err = 1'b0;
    r   = '0;
    case (op)
      2'd0, 2'd1: begin
        v = (op == 2'd0) ? va + vb : va - vb;
        r = {v < 0, 8'(iabs(v))};
      end
      2'd2: begin
        m = 16'(a[7:0]) * 16'(b[7:0]);
        r = {a[8] ^ b[8], m[7:0]};
      end
      default: begin
        if (b[7:0] == 8'd0) err = 1'b1;
        else r = {a[8] ^ b[8], a[7:0] / b[7:0]};
      end
    endcase
  endfunction

  task automatic compare_state(input string t);
    chk({t, ".acc"}, acc, enc(m_acc));
    chk({t, ".step_count"}, step_count, m_steps);
    chk({t, ".flag_zero"}, flag_zero, m_acc == 0);
    chk({t, ".flag_sign"}, flag_sign, m_acc < 0);
    chk({t, ".flag_error"}, flag_error, m_err);
    chk({t, ".err_timeout"}, err_timeout, m_to);
    chk({t, ".done"}, done, m_done);
    chk({t, ".in_ready"}, in_ready, !m_halt);
    chk({t, ".busy"}, busy, 0);
    chk({t, ".alu_start"}, alu_start, 0);
  endtask

  task automatic apply_reset();
    Reset = 1'b1; in_valid = 1'b0; alu_done = 1'b0; alu_error = 1'b0;
    alu_result = '0; in_operand = '0; in_op = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_acc = 0; m_steps = 0; m_halt = 0; m_err = 0; m_to = 0; m_done = 0;
  endtask

  // mode 0: ALU answers after lat cycles; 1: ALU flags an error; 2: ALU never answers.
  task automatic offer(input logic [2:0] opd, input logic [1:0] op, input int mode, input int lat);
    int w, bval, amag, aval, r;
    logic [8:0] ea, eb, res;
    logic aerr;
    in_operand = opd; in_op = op; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge Clk); w++; end
    if (!in_ready) begin
      chk("accept_wait", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge Clk);
    in_valid = 1'b0;
    bval = sm_val(opd);
    if (m_steps == 0) begin
      m_acc = bval; m_steps = 1;
      compare_state("first");
      return;
    end
    amag = iabs(m_acc) % 128;
    aval = (m_acc < 0) ? -amag : amag;
    ea = {m_acc < 0, 1'b0, 7'(amag)};
    eb = enc(bval);
    chk("issue.alu_start", alu_start, 1);
    chk("issue.alu_a", alu_a, ea);
    chk("issue.alu_b", alu_b, eb);
    chk("issue.alu_op", alu_op, op);
    chk("issue.in_ready", in_ready, 0);
    last_a = alu_a;
    @(negedge Clk);
    chk("wait.alu_start", alu_start, 0);
    chk("wait.busy", busy, 1);
    if (mode == 2) begin
      repeat (ALU_TIMEOUT - 1) @(negedge Clk);
      chk("timeout.early_error", flag_error, 0);
      chk("timeout.busy", busy, 1);
      @(negedge Clk);
      m_err = 1; m_to = 1; m_halt = 1;
      compare_state("timeout");
      return;
    end
    repeat (lat - 1) @(negedge Clk);
    alu_fn(alu_a, alu_b, alu_op, res, aerr);
    alu_done = 1'b1; alu_result = res; alu_error = aerr | (mode == 1);
    @(negedge Clk);
    alu_done = 1'b0; alu_result = '0; alu_error = 1'b0;
    @(negedge Clk);
    if (mode == 1 || (op == 2'd3 && bval == 0)) begin
      m_err = 1; m_halt = 1;
    end else begin
      case (op)
        2'd0:    r = aval + bval;
        2'd1:    r = aval - bval;
        2'd2:    r = aval * bval;
        default: r = aval / bval;
      endcase
      m_acc = (r < 0) ? -(iabs(r) % 256) : (iabs(r) % 256);
      m_steps++;
      if (m_steps == MAX_OPS) begin m_done = 1; m_halt = 1; end
    end
    compare_state("op");
  endtask

  task automatic hold_rejected(input string t);
    int seen = 0;
    in_valid = 1'b1; in_operand = 3'b001; in_op = 2'd0;
    repeat (20) begin
      @(negedge Clk);
      if (in_ready) seen++;
    end
    in_valid = 1'b0;
    chk({t, ".never_ready"}, seen, 0);
    compare_state(t);
  endtask

  typedef struct {
    logic [2:0] opd;
    logic [1:0] op;
    int         lat;
    logic [8:0] exp_acc;
    logic [3:0] exp_steps;
    logic [6:0] exp_amag;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{3'b011, 2'd0, 3, 9'h003, 4'd1, 7'd0};
    tbl[1] = '{3'b010, 2'd0, 3, 9'h005, 4'd2, 7'd3};
    tbl[2] = '{3'b111, 2'd2, 3, 9'h10F, 4'd3, 7'd5};
    tbl[3] = '{3'b001, 2'd1, 3, 9'h110, 4'd4, 7'd15};
    tbl[4] = '{3'b010, 2'd3, 3, 9'h108, 4'd5, 7'd16};
    tbl[5] = '{3'b011, 2'd0, 1, 9'h003, 4'd1, 7'd0};
    tbl[6] = '{3'b011, 2'd2, 1, 9'h009, 4'd2, 7'd3};
    tbl[7] = '{3'b011, 2'd2, 2, 9'h01B, 4'd3, 7'd9};
    tbl[8] = '{3'b011, 2'd2, 3, 9'h051, 4'd4, 7'd27};
    tbl[9] = '{3'b011, 2'd2, 4, 9'h0F3, 4'd5, 7'd81};

    apply_reset();
    compare_state("reset");
    chk("reset.alu_a", alu_a, 0);
    chk("reset.alu_b", alu_b, 0);
    chk("reset.alu_op", alu_op, 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 5) apply_reset();
      offer(tbl[i].opd, tbl[i].op, 0, tbl[i].lat);
      chk("tbl.acc", acc, tbl[i].exp_acc);
      chk("tbl.step_count", step_count, tbl[i].exp_steps);
      if (i != 0 && i != 5) chk("tbl.alu_a_mag", last_a[6:0], tbl[i].exp_amag);
      if (i == 4 || i == 9) begin
        chk("tbl.done", done, 1);
        chk("tbl.in_ready", in_ready, 0);
      end
    end
    chk("chain.flag_sign_end", flag_sign, 0);

    // Zero result and negative-zero operands
    apply_reset();
    offer(3'b010, 2'd0, 0, 2);
    offer(3'b010, 2'd1, 0, 2);
    chk("zero.acc", acc, 9'h000);
    chk("zero.flag_zero", flag_zero, 1);
    offer(3'b100, 2'd0, 0, 1);
    chk("negzero_add.acc", acc, 9'h000);
    chk("negzero_add.flag_sign", flag_sign, 0);
    apply_reset();
    offer(3'b100, 2'd0, 0, 1);
    chk("negzero_first.acc", acc, 9'h000);

    // Divide by zero halts until reset
    apply_reset();
    offer(3'b011, 2'd0, 0, 1);
    offer(3'b000, 2'd3, 0, 2);
    chk("div0.flag_error", flag_error, 1);
    chk("div0.err_timeout", err_timeout, 0);
    chk("div0.acc", acc, 9'h003);
    chk("div0.step_count", step_count, 1);
    hold_rejected("div0_halt");

    // ALU never answers
    apply_reset();
    offer(3'b001, 2'd0, 0, 1);
    offer(3'b001, 2'd0, 2, 0);
    chk("timeout.acc", acc, 9'h001);
    hold_rejected("timeout_halt");

    // Reset during WAIT_ALU, then a stale alu_done
    apply_reset();
    offer(3'b001, 2'd0, 0, 1);
    in_valid = 1'b1; in_operand = 3'b001; in_op = 2'd0;
    @(negedge Clk);
    in_valid = 1'b0;
    chk("midreset.issue", alu_start, 1);
    repeat (2) @(negedge Clk);
    chk("midreset.busy_before", busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; alu_done = 1'b1; alu_result = 9'h005;
    @(negedge Clk);
    alu_done = 1'b0; alu_result = '0;
    m_acc = 0; m_steps = 0; m_halt = 0; m_err = 0; m_to = 0; m_done = 0;
    compare_state("midreset");
    offer(3'b010, 2'd0, 0, 1);
    chk("midreset.reload", acc, 9'h002);

    // Randomized chains
    for (int run = 0; run < 30; run++) begin
      apply_reset();
      for (int k = 0; k < 12 && !m_halt; k++) begin
        offer(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 15) == 0) ? 1 : 0, $urandom_range(1, 4));
      end
      chk("rand.halted", in_ready, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
